frame_readback: RTL and testbench



---
 rtl/frame_pkg.sv | 21 ++
 rtl/frame_readback.sv | 117 +++++++++++
 tb/tb_frame_readback.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_pkg.sv
// Shared frame definitions for the panel frame-buffer read and write paths.
// Holds the readback FSM state encoding, default panel dimensions and the frame length helper.
package frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    SEND,
    CSUM,
    FIN
  } frame_state_t;

  localparam int PANEL_HEIGHT = 16;
  localparam int PANEL_WIDTH  = 32;

  function automatic int frame_len(input int height, input int width);
    return height * width;
  endfunction

endpackage

// File: rtl/frame_readback.sv
// Streams frame-buffer bytes 0..N-1 (plus a mod-256 sum byte under FRAME_READBACK_CHECKSUM_EN) to the UART TX.
// Latency: first tx_valid 3 cycles after start (READ, WAIT, SEND); 3-cycle byte spacing with tx_ready high.
// Backpressure: holds tx_valid/tx_data in SEND until tx_ready; stalls indefinitely, start ignored unless IDLE.
module frame_readback
  import frame_pkg::*;
#(
  parameter int HEIGHT     = PANEL_HEIGHT,
  parameter int WIDTH      = PANEL_WIDTH,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready
);

  localparam int N = frame_len(HEIGHT, WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N - 1);

  frame_state_t          state_q;
  frame_state_t          state_d;
  logic [ADDR_WIDTH-1:0] count_q;
  logic [7:0]            byte_q;
  logic                  pixel_hs;

  // Derived from state rather than tx_valid to keep the handshake free of comb feedback.
  assign pixel_hs = (state_q == SEND) && tx_ready;
  assign rd_addr  = count_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
      byte_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == WAIT) begin
        byte_q <= 8'(rd_data);
      end
      if (state_q == FIN) begin
        count_q <= '0;
      end else if (pixel_hs && (count_q != LAST_ADDR)) begin
        count_q <= count_q + ADDR_WIDTH'(1);
      end
    end
  end

`ifdef FRAME_READBACK_CHECKSUM_EN
  logic [7:0] sum_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sum_q <= '0;
    end else if ((state_q == IDLE) && start) begin
      sum_q <= '0;
    end else if (pixel_hs) begin
      sum_q <= sum_q + byte_q;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    busy     = 1'b0;
    done     = 1'b0;
    rd_en    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = byte_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = READ;
      end
      READ: begin
        busy    = 1'b1;
        rd_en   = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        busy    = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        if (tx_ready) begin
`ifdef FRAME_READBACK_CHECKSUM_EN
          state_d = (count_q == LAST_ADDR) ? CSUM : READ;
`else
          state_d = (count_q == LAST_ADDR) ? FIN : READ;
`endif
        end
      end
`ifdef FRAME_READBACK_CHECKSUM_EN
      CSUM: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = sum_q;
        if (tx_ready) state_d = FIN;
      end
`endif
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_frame_readback.sv
// Self-checking bench for frame_readback: default 16x32 instance against a queue model, plus a 1x2 instance.
// Build with or without FRAME_READBACK_CHECKSUM_EN; expected frame length follows the macro.
module tb_frame_readback;

  localparam int H  = 16;
  localparam int W  = 32;
  localparam int N  = H * W;
  localparam int AW = 16;
`ifdef FRAME_READBACK_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  localparam int EXP_LEN = N + CS;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset_n = 1'b0;
  logic          start   = 1'b0;
  logic          tx_ready = 1'b0;
  logic          busy, done, rd_en, tx_valid;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data = '0;
  logic [7:0]    tx_data;
  logic [7:0]    mem [0:N-1];

  logic          s_start = 1'b0;
  logic          s_tx_ready = 1'b1;
  logic          s_busy, s_done, s_rd_en, s_tx_valid;
  logic [AW-1:0] s_rd_addr;
  logic [7:0]    s_rd_data = '0;
  logic [7:0]    s_tx_data;
  logic [7:0]    s_mem [0:1];

  frame_readback #(.HEIGHT(H), .WIDTH(W), .ADDR_WIDTH(AW), .DATA_WIDTH(8)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  frame_readback #(.HEIGHT(1), .WIDTH(2), .ADDR_WIDTH(AW), .DATA_WIDTH(8)) dut_small (
    .clock(clock), .reset_n(reset_n), .start(s_start), .busy(s_busy), .done(s_done),
    .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_data(s_rd_data),
    .tx_data(s_tx_data), .tx_valid(s_tx_valid), .tx_ready(s_tx_ready)
  );

  // Frame buffers: synchronous read, data valid the cycle after rd_en.
  always @(posedge clock) if (rd_en) rd_data <= mem[rd_addr[8:0]];
  always @(posedge clock) if (s_rd_en) s_rd_data <= s_mem[s_rd_addr[0]];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Ready generator: fixed level or ~30% random high.
  bit rand_mode   = 0;
  bit ready_level = 1;
  always @(posedge clock) begin
    #1;
    tx_ready = rand_mode ? ($urandom_range(0, 9) < 3) : ready_level;
  end

  // Model: expected byte stream for the frame in flight; every handshake pops one byte.
  logic [7:0] exp_q [$];
  logic [7:0] rx_q  [$];
  bit         mon_en   = 0;
  bit         done_due = 0;
  bit         pv_stall = 0;
  logic [7:0] pv_data  = '0;
  int         hs_count = 0;
  int         rd_count = 0;

  always @(negedge clock) begin
    if (mon_en) begin
      check("done_pulse", done, done_due);
      if (done_due) check("busy_low_at_done", busy, 1'b0);
      done_due = 0;
      if (pv_stall) begin
        check("hold_valid", tx_valid, 1'b1);
        check("hold_data", tx_data, pv_data);
      end
      if (tx_valid) check("busy_while_valid", busy, 1'b1);
      if (rd_en) begin
        rd_count++;
        check("rd_addr_range", rd_addr < AW'(N), 1'b1);
      end
      if (tx_valid && tx_ready) begin
        rx_q.push_back(tx_data);
        hs_count++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_byte: got %0h expected no byte after frame end", tx_data);
        end else begin
          check("tx_byte", tx_data, exp_q.pop_front());
          if (exp_q.size() == 0) done_due = 1;
        end
      end
      pv_stall = tx_valid && !tx_ready;
      pv_data  = tx_data;
    end
  end

  logic [AW-1:0] s_max_addr = '0;
  logic [7:0]    s_rx_q [$];
  always @(negedge clock) begin
    if (s_rd_en && s_rd_addr > s_max_addr) s_max_addr = s_rd_addr;
    if (s_tx_valid && s_tx_ready) s_rx_q.push_back(s_tx_data);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_frame(input bit ones);
    for (int i = 0; i < N; i++) mem[i] = ones ? 8'h01 : 8'(i);
  endtask

  task automatic arm();
    logic [7:0] sum;
    sum = '0;
    exp_q.delete();
    rx_q.delete();
    for (int i = 0; i < N; i++) begin
      exp_q.push_back(mem[i]);
      sum = sum + mem[i];
    end
    if (CS != 0) exp_q.push_back(sum);
    hs_count = 0;
    rd_count = 0;
    done_due = 0;
    pv_stall = 0;
    mon_en   = 1;
  endtask

  task automatic wait_hs(input int n, input int budget);
    int k = 0;
    while (hs_count < n && k < budget) begin
      tick();
      k++;
    end
    check("wait_hs_timeout", hs_count >= n, 1'b1);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    check("wait_done_timeout", done, 1'b1);
  endtask

  task automatic run_frame(input int budget);
    arm();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(budget);
    tick();
    check("frame_complete", exp_q.size(), 0);
    check("idle_after_frame", busy, 1'b0);
  endtask

  initial begin
    s_mem[0] = 8'h12;
    s_mem[1] = 8'h34;
    load_frame(0);

    // Reset values
    tick();
    tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rd_en", rd_en, 1'b0);
    check("rst_rd_addr", rd_addr, '0);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    reset_n = 1'b1;
    tick();

    // Ramp frame, ready held high, latency pinned by hand
    arm();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("lat_busy", busy, 1'b1);
    check("lat_rd_en", rd_en, 1'b1);
    check("lat_rd_addr0", rd_addr, '0);
    check("lat_valid_c1", tx_valid, 1'b0);
    tick();
    check("lat_rd_en_once", rd_en, 1'b0);
    check("lat_valid_c2", tx_valid, 1'b0);
    tick();
    check("lat_valid_c3", tx_valid, 1'b1);
    check("lat_first_data", tx_data, 8'h00);
    wait_done(3000);
    tick();
    check("ramp_complete", exp_q.size(), 0);
    check("ramp_len", rx_q.size(), EXP_LEN);
    check("ramp_rd_count", rd_count, 512);
    if (rx_q.size() >= 512) begin
      check("pin_byte0", rx_q[0], 8'h00);
      check("pin_byte255", rx_q[255], 8'hFF);
      check("pin_byte256", rx_q[256], 8'h00);
      check("pin_byte511", rx_q[511], 8'hFF);
    end
`ifdef FRAME_READBACK_CHECKSUM_EN
    if (rx_q.size() >= 513) check("pin_csum_ramp", rx_q[512], 8'h00);
`else
    check("pin_no_extra", rx_q.size(), 512);
`endif

    // Random backpressure
    rand_mode = 1;
    run_frame(20000);
    check("bp_len", rx_q.size(), EXP_LEN);
    rand_mode = 0;
    tick();

    // Start held / re-pulsed mid-frame and coincident with done
    arm();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_hs(5, 100);
    start = 1'b1;
    repeat (4) tick();
    start = 1'b0;
    wait_hs(300, 2000);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(3000);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    check("ign_busy", busy, 1'b0);
    check("ign_valid", tx_valid, 1'b0);
    check("ign_len", hs_count, EXP_LEN);
    check("ign_complete", exp_q.size(), 0);
    run_frame(3000);
    check("second_len", rx_q.size(), EXP_LEN);

    // Reset asserted mid-frame during byte 100
    arm();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_hs(100, 1000);
    tick();
    #2;
    mon_en  = 0;
    reset_n = 1'b0;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_rd_en", rd_en, 1'b0);
    check("arst_rd_addr", rd_addr, '0);
    check("arst_tx_valid", tx_valid, 1'b0);
    check("arst_tx_data", tx_data, 8'h00);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    arm();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_rd_en", rd_en, 1'b1);
    check("restart_addr0", rd_addr, '0);
    wait_done(3000);
    tick();
    check("restart_complete", exp_q.size(), 0);
    if (rx_q.size() >= 2) begin
      check("restart_byte0", rx_q[0], 8'h00);
      check("restart_byte1", rx_q[1], 8'h01);
    end

    // All-ones frame
    load_frame(1);
    run_frame(3000);
    check("ones_len", rx_q.size(), EXP_LEN);
    if (rx_q.size() >= 512) begin
      check("ones_byte0", rx_q[0], 8'h01);
      check("ones_byte511", rx_q[511], 8'h01);
    end
`ifdef FRAME_READBACK_CHECKSUM_EN
    if (rx_q.size() >= 513) check("pin_csum_ones", rx_q[512], 8'h00);
`endif
    mon_en = 0;

    // 1x2 instance
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    check("s_rd_en", s_rd_en, 1'b1);
    check("s_rd_addr0", s_rd_addr, '0);
    tick();
    check("s_valid_c2", s_tx_valid, 1'b0);
    tick();
    check("s_valid_c3", s_tx_valid, 1'b1);
    check("s_first_data", s_tx_data, 8'h12);
    begin
      int k = 0;
      while (s_done !== 1'b1 && k < 50) begin
        tick();
        k++;
      end
      check("s_done_timeout", s_done, 1'b1);
    end
    tick();
    check("s_busy_end", s_busy, 1'b0);
    check("s_len", s_rx_q.size(), 2 + CS);
    check("s_max_addr", s_max_addr, 16'd1);
    if (s_rx_q.size() >= 2) begin
      check("s_byte0", s_rx_q[0], 8'h12);
      check("s_byte1", s_rx_q[1], 8'h34);
    end
`ifdef FRAME_READBACK_CHECKSUM_EN
    if (s_rx_q.size() >= 3) check("s_csum", s_rx_q[2], 8'h46);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
